// File: rtl/out_port_uart_tx.sv
// out_port_uart_tx: serial transmitter for the CPU output port.
// Words written on the out-port strobe are queued in a small FIFO and each
// word is sent as four 8N1 UART frames, least-significant byte first. The
// write side never stalls: a write into a full FIFO is dropped and recorded
// in a sticky overflow flag, unless a pop frees a slot in the same cycle.
module out_port_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        out_port_enable,
   input  logic [31:0] out_port_data_in,
   input  logic        overflow_clr,
   output logic        tx,
   output logic        busy,
   output logic        fifo_full,
   output logic        fifo_empty,
   output logic        overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // FIFO storage and bookkeeping
   logic [31:0]      mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;

   // Shifter state
   state_t      state_q, state_d;
   logic [15:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [31:0] shift_q, shift_d;
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;

   // Handshake between the write side, the FIFO and the shifter
   logic pop;
   logic full_now;
   logic accept;
   logic drop;
   logic baud_last;

   // The shifter only pulls a word while sitting in IDLE; the registered count
   // means a word written this cycle is first seen by IDLE next cycle.
   assign pop       = (state_q == IDLE) && (count_q != '0);
   assign full_now  = (count_q == FULL_CNT);
   // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
   assign accept    = out_port_enable && (!full_now || pop);
   assign drop      = out_port_enable && full_now && !pop;
   assign baud_last = (baud_cnt_q == BAUD_LAST);

   // FIFO pointer, count, flag and overflow next-state logic
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (accept) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end

      case ({accept, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // A dropping write takes priority over a clear in the same cycle.
      if (drop) begin
         overflow_d = 1'b1;
      end else if (overflow_clr) begin
         overflow_d = 1'b0;
      end

      // Flags are registered copies of decodes of the next count.
      full_d  = (count_d == FULL_CNT);
      empty_d = (count_d == '0);
   end

   // Shifter next-state logic and registered serial outputs
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      shift_d    = shift_q;

      case (state_q)
         IDLE: begin
            if (pop) begin
               shift_d    = mem_q[rd_ptr_q];
               byte_idx_d = '0;
               bit_idx_d  = '0;
               baud_cnt_d = '0;
               state_d    = START;
            end
         end

         START: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               bit_idx_d  = '0;
               state_d    = DATA;
            end else begin
               baud_cnt_d = baud_cnt_q + 16'd1;
            end
         end

         DATA: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 16'd1;
            end
         end

         STOP: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               // Bytes of one word run back to back with no idle gap.
               if (byte_idx_q != 2'd3) begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  state_d    = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 16'd1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Line level and busy follow the state being entered so that they
      // change on the same edge as the state register.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[{byte_idx_d, bit_idx_d}];
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   // Control registers; reset abandons any frame and discards queued words
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         state_q    <= IDLE;
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
      end
   end

   // Data registers: FIFO storage and shift word carry no reset, since the
   // count and state already mark their contents as invalid after reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem_q[wr_ptr_q] <= out_port_data_in;
      end
      shift_q <= shift_d;
   end

   assign tx         = tx_q;
   assign busy       = busy_q;
   assign fifo_full  = full_q;
   assign fifo_empty = empty_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_out_port_uart_tx.sv
// tb_out_port_uart_tx: scoreboard bench for out_port_uart_tx.
// Expected words are queued as they are written; a line monitor decodes the
// serial output into words, and each scenario task compares the two.
module tb_out_port_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        out_port_enable;
   logic [31:0] out_port_data_in;
   logic        overflow_clr;
   logic        tx;
   logic        busy;
   logic        fifo_full;
   logic        fifo_empty;
   logic        overflow;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int frame_err = 0;

   logic [31:0] exp_q[$];
   logic [31:0] rx_q[$];
   int          rx_start_q[$];

   out_port_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .out_port_enable (out_port_enable),
      .out_port_data_in(out_port_data_in),
      .overflow_clr    (overflow_clr),
      .tx              (tx),
      .busy            (busy),
      .fifo_full       (fifo_full),
      .fifo_empty      (fifo_empty),
      .overflow        (overflow)
   );

   // clock
   initial forever #5 clk = ~clk;

   // cycle counter
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   // Serial line monitor: decodes 8N1 frames (CPB clocks per bit) into words.
   initial begin
      int          cnt;
      int          byte_n;
      bit          active;
      int          word_start;
      logic [7:0]  rx_byte;
      logic [31:0] rx_word;
      cnt = 0; byte_n = 0; active = 0; word_start = 0;
      rx_byte = '0; rx_word = '0;
      forever begin
         @(negedge clk);
         if (reset === 1'b1) begin
            active = 0;
            byte_n = 0;
            cnt    = 0;
         end else if (!active) begin
            if (tx === 1'b0) begin
               active = 1;
               cnt    = 0;
               if (byte_n == 0) word_start = cyc;
            end
         end else begin
            cnt++;
            if (cnt == CPB / 2 && tx !== 1'b0) frame_err++;
            if (cnt >= CPB + CPB / 2 && cnt < 9 * CPB && ((cnt - CPB - CPB / 2) % CPB) == 0)
               rx_byte[(cnt - CPB - CPB / 2) / CPB] = tx;
            if (cnt == 9 * CPB + CPB / 2 && tx !== 1'b1) frame_err++;
            if (cnt == 10 * CPB - 1) begin
               active = 0;
               rx_word[8 * byte_n +: 8] = rx_byte;
               if (byte_n == 3) begin
                  rx_q.push_back(rx_word);
                  rx_start_q.push_back(word_start);
                  byte_n = 0;
               end else begin
                  byte_n++;
               end
            end
         end
      end
   end

   // drive one write; called at a negedge, returns at the next negedge
   task automatic write_word(input logic [31:0] data);
      out_port_enable  = 1'b1;
      out_port_data_in = data;
      @(negedge clk);
      out_port_enable  = 1'b0;
   endtask

   task automatic wait_rx(input int n, input int budget);
      int k = 0;
      while (rx_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (!(busy === 1'b0 && fifo_empty === 1'b1) && k < budget) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
   endtask

   // pop n expected and n received words and compare them in order
   task automatic drain_compare(input string name, input int n, input int budget);
      logic [31:0] e, a;
      wait_rx(n, budget);
      checks++;
      if (rx_q.size() != n) begin
         errors++;
         $display("FAIL %s_count got %0d words want %0d", name, rx_q.size(), n);
      end
      for (int i = 0; i < n; i++) begin
         if (rx_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = rx_q.pop_front();
            void'(rx_start_q.pop_front());
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL %s_word%0d got %h want %h", name, i, a, e);
            end
         end
      end
      rx_q.delete();
      rx_start_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset;
      reset = 1'b1; out_port_enable = 1'b0; out_port_data_in = '0; overflow_clr = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", fifo_full); end
      checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", fifo_empty); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (tx !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL post_reset_idle got tx=%b busy=%b want tx=1 busy=0", tx, busy);
      end
   endtask

   task automatic test_single_word;
      int n = 0;
      write_word(32'h12345678);
      exp_q.push_back(32'h12345678);
      checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL single_empty_after_write got %b want 0", fifo_empty); end
      @(negedge clk);
      checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL single_empty_after_pop got %b want 1", fifo_empty); end
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL single_first_start got %b want 0", tx); end
      for (int i = 0; i < 200; i++) begin
         if (busy === 1'b1) n++;
         @(negedge clk);
      end
      checks++; if (n != 40 * CPB) begin errors++; $display("FAIL single_busy_cycles got %0d want %0d", n, 40 * CPB); end
      drain_compare("single", 1, 100);
   endtask

   task automatic test_back_to_back;
      int s0, s1;
      wait_idle(500);
      write_word(32'hA5A5A5A5);
      write_word(32'h000000FF);
      exp_q.push_back(32'hA5A5A5A5);
      exp_q.push_back(32'h000000FF);
      wait_rx(2, 500);
      checks++;
      if (rx_start_q.size() >= 2) begin
         s0 = rx_start_q[0];
         s1 = rx_start_q[1];
         if (s1 - s0 != 40 * CPB + 1) begin
            errors++; $display("FAIL b2b_gap got %0d want %0d", s1 - s0, 40 * CPB + 1);
         end
      end else begin
         errors++; $display("FAIL b2b_gap got %0d words want 2", rx_start_q.size());
      end
      drain_compare("b2b", 2, 10);
   endtask

   task automatic test_overflow;
      wait_idle(500);
      for (int v = 1; v <= 6; v++) write_word(32'(v));
      for (int v = 1; v <= 5; v++) exp_q.push_back(32'(v));
      checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", fifo_full); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
      drain_compare("ovf", 5, 1200);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
      overflow_clr = 1'b1;
      @(negedge clk);
      overflow_clr = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
   endtask

   task automatic test_full_pop;
      int k = 0;
      wait_idle(1500);
      for (int i = 0; i < 5; i++) begin
         write_word(32'hC0DE0000 + 32'(i));
         exp_q.push_back(32'hC0DE0000 + 32'(i));
      end
      checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fullpop_full_before got %b want 1", fifo_full); end
      while (busy !== 1'b0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fullpop_idle_timeout got busy=%b want 0", busy); end
      write_word(32'hDEADBEEF);
      exp_q.push_back(32'hDEADBEEF);
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow got %b want 0", overflow); end
      checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fullpop_full_after got %b want 1", fifo_full); end
      drain_compare("fullpop", 6, 1500);
   endtask

   task automatic test_reset_mid_frame;
      int zeros = 0;
      wait_idle(500);
      write_word(32'h0F0F0F0F);
      write_word(32'h11223344);
      write_word(32'h55667788);
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rstmid_start got %b want 0", tx); end
      // now one cycle into the start bit; move into byte 1, data bit 3
      repeat (10 * CPB + CPB + 3 * CPB + 1) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
      reset = 1'b1;
      #1;
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx got %b want 1", tx); end
      checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got %b want 1", fifo_empty); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) zeros++;
      end
      checks++; if (zeros != 0) begin errors++; $display("FAIL rstmid_quiet got %0d low cycles want 0", zeros); end
      checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL rstmid_rx got %0d words want 0", rx_q.size()); end
      rx_q.delete();
      rx_start_q.delete();
   endtask

   task automatic test_clr_set_race;
      wait_idle(500);
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL race_pre got %b want 0", overflow); end
      for (int i = 0; i < 5; i++) begin
         write_word(32'h0BADF000 + 32'(i));
         exp_q.push_back(32'h0BADF000 + 32'(i));
      end
      overflow_clr = 1'b1;
      write_word(32'hFFFFFFFF);
      overflow_clr = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL race_set_wins got %b want 1", overflow); end
      overflow_clr = 1'b1;
      @(negedge clk);
      overflow_clr = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL race_clear got %b want 0", overflow); end
      drain_compare("race", 5, 1200);
   endtask

   task automatic test_framing;
      checks++; if (frame_err != 0) begin errors++; $display("FAIL framing got %0d bad start/stop want 0", frame_err); end
   endtask

   initial begin
      reset = 1'b1;
      out_port_enable = 1'b0;
      out_port_data_in = '0;
      overflow_clr = 1'b0;
      @(negedge clk);
      test_reset();
      test_single_word();
      test_back_to_back();
      test_overflow();
      test_full_pop();
      test_reset_mid_frame();
      test_clr_set_race();
      test_framing();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
